// File: rtl/write_buffer_pkg.sv
// Shared memory-subsystem definitions: memory FSM encoding, buffered entry layout, depth default.
package write_buffer_pkg;

    localparam int WB_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/write_buffer_fifo.sv
// Circular entry store for the write buffer; exposes head entry and whole array for address matching.
// Latency: a pushed entry is visible on head/entries/count the cycle after the push edge.
// Backpressure: push is ignored while full and pop is ignored while empty; the caller gates both.
module wb_fifo
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output wb_entry_t                head,
    output wb_entry_t                entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0] head_ptr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] tail_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[head_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + PW'(1);
            if (do_pop)  head_ptr <= head_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Payload needs no reset: count and pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) entries[tail_ptr] <= push_entry;
    end

endmodule

// File: rtl/write_buffer.sv
// Posted-write buffer between data cache and memory; optional read forwarding via WRITE_BUFFER_FORWARD_EN.
// Latency: write ack one cycle after accept; read data one cycle after memory_response (forward hit: one cycle).
// Backpressure: writes stall while full; reads wait for a full drain unless forwarding lets a miss bypass.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cache_read_request,
    input  logic        cache_write_request,
    input  logic [31:0] cache_addr,
    input  logic [31:0] cache_write_data,
    output logic        cache_response,
    output logic [31:0] cache_read_data,
    output logic        memory_read_request,
    output logic        memory_write_request,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_write_data,
    input  logic        memory_response,
    input  logic [31:0] memory_read_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    mem_state_t    state, state_next;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [PW:0]   fifo_count;
    wb_entry_t     fifo_head;
    wb_entry_t     fifo_entries [DEPTH];
    logic [PW-1:0] fifo_head_ptr;
    logic          rd_req_ok, read_eligible, fwd_take, read_done;
    logic [31:0]   fwd_data;
    logic          mem_rd_next, mem_wr_next;
    logic [31:0]   mem_addr_next, mem_data_next;

    // While the ack pulse is out the cache is still holding the old request; ignore it.
    assign fifo_push = cache_write_request && !fifo_full && !cache_response;
    assign rd_req_ok = cache_read_request && !cache_write_request && !cache_response;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry ({cache_addr, cache_write_data}),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head       (fifo_head),
        .entries    (fifo_entries),
        .head_ptr   (fifo_head_ptr)
    );

`ifdef WRITE_BUFFER_FORWARD_EN
    logic          fwd_hit;
    logic [PW-1:0] fwd_idx;

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = fifo_head_ptr + PW'(i);
            if (CW'(i) < fifo_count && fifo_entries[fwd_idx].addr[31:2] == cache_addr[31:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_entries[fwd_idx].data;
            end
        end
    end

    assign fwd_take      = rd_req_ok && fwd_hit && (state != READ);
    assign read_eligible = rd_req_ok && !fwd_hit;
`else
    logic unused_fwd;

    always_comb begin
        unused_fwd = ^fifo_head_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            unused_fwd = unused_fwd ^ (^fifo_entries[i]);
        end
    end

    assign fwd_take      = 1'b0;
    assign fwd_data      = '0;
    assign read_eligible = rd_req_ok && fifo_empty;
`endif

    always_comb begin
        state_next    = state;
        mem_rd_next   = 1'b0;
        mem_wr_next   = 1'b0;
        mem_addr_next = '0;
        mem_data_next = '0;
        fifo_pop      = 1'b0;
        read_done     = 1'b0;
        case (state)
            IDLE: begin
                if (read_eligible) begin
                    state_next    = READ;
                    mem_rd_next   = 1'b1;
                    mem_addr_next = cache_addr;
                end else if (!fifo_empty) begin
                    state_next    = WRITE;
                    mem_wr_next   = 1'b1;
                    mem_addr_next = fifo_head.addr;
                    mem_data_next = fifo_head.data;
                end
            end
            WRITE: begin
                if (memory_response) begin
                    state_next = IDLE;
                    fifo_pop   = 1'b1;
                end else begin
                    mem_wr_next   = 1'b1;
                    mem_addr_next = fifo_head.addr;
                    mem_data_next = fifo_head.data;
                end
            end
            READ: begin
                if (memory_response) begin
                    state_next = IDLE;
                    read_done  = 1'b1;
                end else begin
                    mem_rd_next   = 1'b1;
                    mem_addr_next = cache_addr;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            memory_read_request  <= 1'b0;
            memory_write_request <= 1'b0;
            memory_addr          <= '0;
            memory_write_data    <= '0;
            cache_response       <= 1'b0;
            cache_read_data      <= '0;
        end else begin
            state                <= state_next;
            memory_read_request  <= mem_rd_next;
            memory_write_request <= mem_wr_next;
            memory_addr          <= mem_addr_next;
            memory_write_data    <= mem_data_next;
            cache_response       <= fifo_push || read_done || fwd_take;
            if (read_done)
                cache_read_data <= memory_read_data;
            else if (fwd_take)
                cache_read_data <= fwd_data;
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: scripted cache stimulus, behavioural memory with stall/latency, queue scoreboard.
module tb_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cache_read_request, cache_write_request;
    logic [31:0] cache_addr, cache_write_data;
    logic        cache_response;
    logic [31:0] cache_read_data;
    logic        memory_read_request, memory_write_request;
    logic [31:0] memory_addr, memory_write_data;
    logic        memory_response;
    logic [31:0] memory_read_data;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_wr_q [$];
    logic [63:0] mem_seen_q [$];
    logic [31:0] exp_rd_q [$];

    bit          mem_stall;
    int          mem_lat;
    logic [31:0] mem_rdata;
    logic [31:0] last_rd_addr = '0;
    int          wait_cnt = 0;
    int          wr_req_cycles = 0;
    int          rd_req_cycles = 0;
    int          resp_cnt = 0;
    int          idle_bad = 0;

    always #5 clk = ~clk;

    write_buffer #(.DEPTH(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cache_read_request   (cache_read_request),
        .cache_write_request  (cache_write_request),
        .cache_addr           (cache_addr),
        .cache_write_data     (cache_write_data),
        .cache_response       (cache_response),
        .cache_read_data      (cache_read_data),
        .memory_read_request  (memory_read_request),
        .memory_write_request (memory_write_request),
        .memory_addr          (memory_addr),
        .memory_write_data    (memory_write_data),
        .memory_response      (memory_response),
        .memory_read_data     (memory_read_data)
    );

    // Memory model and activity monitor, acting on the falling edge.
    initial begin
        memory_response  = 1'b0;
        memory_read_data = '0;
        forever begin
            @(negedge clk);
            if (memory_write_request) wr_req_cycles++;
            if (memory_read_request)  rd_req_cycles++;
            if (!memory_write_request && !memory_read_request &&
                (memory_addr !== 32'h0 || memory_write_data !== 32'h0)) idle_bad++;
            if (cache_response) resp_cnt++;
            if (memory_response) begin
                memory_response = 1'b0;
            end else if (memory_write_request || memory_read_request) begin
                if (!mem_stall) begin
                    if (wait_cnt >= mem_lat) begin
                        wait_cnt        = 0;
                        memory_response = 1'b1;
                        if (memory_write_request) begin
                            mem_seen_q.push_back({memory_addr, memory_write_data});
                        end else begin
                            memory_read_data = mem_rdata;
                            last_rd_addr     = memory_addr;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d errors, required completion", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int lat);
        @(negedge clk);
        cache_addr          = a;
        cache_write_data    = d;
        cache_write_request = 1'b1;
        exp_wr_q.push_back({a, d});
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (cache_response) begin
                lat = n;
                break;
            end
        end
        cache_write_request = 1'b0;
    endtask

    task automatic wait_seen(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (mem_seen_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cache_response !== 1'b0) begin errors++; $display("FAIL reset_cache_response: got %0b, required 0", cache_response); end
        checks++; if (cache_read_data !== 32'h0) begin errors++; $display("FAIL reset_cache_read_data: got %h, required 0", cache_read_data); end
        checks++; if (memory_read_request !== 1'b0) begin errors++; $display("FAIL reset_mem_rd_req: got %0b, required 0", memory_read_request); end
        checks++; if (memory_write_request !== 1'b0) begin errors++; $display("FAIL reset_mem_wr_req: got %0b, required 0", memory_write_request); end
        checks++; if (memory_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h, required 0", memory_addr); end
        checks++; if (memory_write_data !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h, required 0", memory_write_data); end
        checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", dut.u_fifo.count); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int lat;
        bit seen, ok;
        logic [63:0] obs, exp;
        mem_stall = 1'b0;
        mem_lat   = 2;
        do_write(32'h100, 32'hDEADBEEF, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL single_ack_latency: got %0d, required 1", lat); end
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (memory_write_request) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL single_mem_wr_req: got none, required a request"); end
        checks++; if (memory_addr !== 32'h100) begin errors++; $display("FAIL single_mem_addr: got %h, required 00000100", memory_addr); end
        checks++; if (memory_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_mem_wdata: got %h, required deadbeef", memory_write_data); end
        wait_seen(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_drain: got %0d writes, required 1", mem_seen_q.size()); end
        while (mem_seen_q.size() > 0 && exp_wr_q.size() > 0) begin
            obs = mem_seen_q.pop_front(); exp = exp_wr_q.pop_front();
            checks++; if (obs !== exp) begin errors++; $display("FAIL single_entry: got %h, required %h", obs, exp); end
        end
        checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL single_count: got %0d, required 0", dut.u_fifo.count); end
    endtask

    task automatic test_full_stall();
        int lat, early;
        bit got, ok;
        logic [63:0] obs, exp;
        mem_stall = 1'b1;
        mem_lat   = 0;
        for (int k = 0; k < 4; k++) begin
            do_write(32'h300 + 32'(k * 4), 32'hA000_0000 + 32'(k), lat);
            checks++; if (lat != 1) begin errors++; $display("FAIL full_ack_%0d: got latency %0d, required 1", k, lat); end
        end
        @(negedge clk);
        cache_addr          = 32'h310;
        cache_write_data    = 32'hA000_0004;
        cache_write_request = 1'b1;
        exp_wr_q.push_back({32'h310, 32'hA000_0004});
        early = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (cache_response) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL full_stall_hold: got %0d acks, required 0", early); end
        mem_stall = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            if (memory_response) begin got = 1'b1; break; end
        end
        checks++; if (!got) begin errors++; $display("FAIL full_first_pop: got no memory response, required one"); end
        @(negedge clk);
        checks++; if (cache_response !== 1'b0) begin errors++; $display("FAIL full_pop_edge_ack: got %0b, required 0", cache_response); end
        @(negedge clk);
        checks++; if (cache_response !== 1'b1) begin errors++; $display("FAIL full_accept_after_pop: got %0b, required 1", cache_response); end
        cache_write_request = 1'b0;
        wait_seen(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_drain: got %0d writes, required 5", mem_seen_q.size()); end
        while (mem_seen_q.size() > 0 && exp_wr_q.size() > 0) begin
            obs = mem_seen_q.pop_front(); exp = exp_wr_q.pop_front();
            checks++; if (obs !== exp) begin errors++; $display("FAIL full_order: got %h, required %h", obs, exp); end
        end
    endtask

    task automatic test_fifo_order();
        int lat;
        bit ok;
        logic [63:0] obs, exp;
        mem_stall = 1'b1;
        mem_lat   = 1;
        do_write(32'h10, 32'h0000_000A, lat);
        do_write(32'h20, 32'h0000_000B, lat);
        repeat (3) @(negedge clk);
        checks++; if (mem_seen_q.size() != 0) begin errors++; $display("FAIL order_stalled: got %0d writes, required 0", mem_seen_q.size()); end
        mem_stall = 1'b0;
        wait_seen(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL order_drain: got %0d writes, required 2", mem_seen_q.size()); end
        while (mem_seen_q.size() > 0 && exp_wr_q.size() > 0) begin
            obs = mem_seen_q.pop_front(); exp = exp_wr_q.pop_front();
            checks++; if (obs !== exp) begin errors++; $display("FAIL order_entry: got %h, required %h", obs, exp); end
        end
    endtask

    task automatic test_read();
        bit seen, got;
        logic [31:0] exp, held;
        mem_stall = 1'b0;
        mem_lat   = 3;
        mem_rdata = 32'h12345678;
        exp_rd_q.push_back(32'h12345678);
        @(negedge clk);
        cache_addr         = 32'h80;
        cache_read_request = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (memory_read_request) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || memory_addr !== 32'h80) begin errors++; $display("FAIL read_mem_req: got req %0b addr %h, required 1 and 00000080", seen, memory_addr); end
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (memory_response) begin got = 1'b1; break; end
        end
        @(negedge clk);
        exp = exp_rd_q.pop_front();
        checks++; if (!got || cache_response !== 1'b1) begin errors++; $display("FAIL read_response: got %0b, required 1", cache_response); end
        checks++; if (cache_read_data !== exp) begin errors++; $display("FAIL read_data: got %h, required %h", cache_read_data, exp); end
        cache_read_request = 1'b0;
        held = exp;
        mem_rdata = 32'hFFFF_0000;
        repeat (4) @(negedge clk);
        checks++; if (cache_read_data !== held) begin errors++; $display("FAIL read_hold: got %h, required %h", cache_read_data, held); end
        checks++; if (cache_response !== 1'b0) begin errors++; $display("FAIL read_single_pulse: got %0b, required 0", cache_response); end
    endtask

    task automatic test_forward();
        int lat, rd_base;
        bit ok;
        logic [63:0] obs, exp;
        logic [31:0] rexp;
        mem_stall = 1'b1;
        mem_lat   = 1;
        mem_rdata = 32'h0000_55AA;
        do_write(32'h40, 32'h1, lat);
        do_write(32'h40, 32'h2, lat);
        rd_base = rd_req_cycles;
`ifdef WRITE_BUFFER_FORWARD_EN
        exp_rd_q.push_back(32'h2);
        @(negedge clk);
        cache_addr         = 32'h40;
        cache_read_request = 1'b1;
        @(negedge clk);
        rexp = exp_rd_q.pop_front();
        checks++; if (cache_response !== 1'b1) begin errors++; $display("FAIL fwd_response: got %0b, required 1", cache_response); end
        checks++; if (cache_read_data !== rexp) begin errors++; $display("FAIL fwd_data: got %h, required %h", cache_read_data, rexp); end
        cache_read_request = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rd_req_cycles != rd_base) begin errors++; $display("FAIL fwd_no_mem_read: got %0d read cycles, required %0d", rd_req_cycles, rd_base); end
        mem_stall = 1'b0;
`else
        exp_rd_q.push_back(32'h0000_55AA);
        @(negedge clk);
        cache_addr         = 32'h40;
        cache_read_request = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (rd_req_cycles != rd_base || cache_response !== 1'b0) begin errors++; $display("FAIL nofwd_read_waits: got %0d read cycles ack %0b, required %0d and 0", rd_req_cycles, cache_response, rd_base); end
        mem_stall = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cache_response) begin ok = 1'b1; break; end
        end
        rexp = exp_rd_q.pop_front();
        checks++; if (!ok || mem_seen_q.size() != 2) begin errors++; $display("FAIL nofwd_after_drain: got ack %0b with %0d writes done, required 1 and 2", ok, mem_seen_q.size()); end
        checks++; if (cache_read_data !== rexp) begin errors++; $display("FAIL nofwd_data: got %h, required %h", cache_read_data, rexp); end
        checks++; if (last_rd_addr !== 32'h40) begin errors++; $display("FAIL nofwd_mem_addr: got %h, required 00000040", last_rd_addr); end
        cache_read_request = 1'b0;
`endif
        wait_seen(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fwd_drain: got %0d writes, required 2", mem_seen_q.size()); end
        while (mem_seen_q.size() > 0 && exp_wr_q.size() > 0) begin
            obs = mem_seen_q.pop_front(); exp = exp_wr_q.pop_front();
            checks++; if (obs !== exp) begin errors++; $display("FAIL fwd_write_entry: got %h, required %h", obs, exp); end
        end
    endtask

    task automatic test_simultaneous();
        int lat, rd_base;
        bit ok;
        logic [63:0] obs, exp;
        mem_stall = 1'b0;
        mem_lat   = 1;
        rd_base   = rd_req_cycles;
        @(negedge clk);
        cache_addr          = 32'h60;
        cache_write_data    = 32'h77;
        cache_read_request  = 1'b1;
        cache_write_request = 1'b1;
        exp_wr_q.push_back({32'h60, 32'h77});
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (cache_response) begin lat = n; break; end
        end
        cache_read_request  = 1'b0;
        cache_write_request = 1'b0;
        checks++; if (lat != 1) begin errors++; $display("FAIL simul_ack: got latency %0d, required 1", lat); end
        wait_seen(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_drain: got %0d writes, required 1", mem_seen_q.size()); end
        while (mem_seen_q.size() > 0 && exp_wr_q.size() > 0) begin
            obs = mem_seen_q.pop_front(); exp = exp_wr_q.pop_front();
            checks++; if (obs !== exp) begin errors++; $display("FAIL simul_entry: got %h, required %h", obs, exp); end
        end
        checks++; if (rd_req_cycles != rd_base) begin errors++; $display("FAIL simul_no_read: got %0d read cycles, required %0d", rd_req_cycles, rd_base); end
    endtask

    task automatic test_reset_during_write();
        int lat, wr_base, resp_base;
        mem_stall = 1'b1;
        mem_lat   = 0;
        do_write(32'h200, 32'h1111, lat);
        do_write(32'h204, 32'h2222, lat);
        do_write(32'h208, 32'h3333, lat);
        @(negedge clk);
        checks++; if (memory_write_request !== 1'b1 || dut.u_fifo.count !== 3'd3) begin errors++; $display("FAIL rstw_setup: got req %0b count %0d, required 1 and 3", memory_write_request, dut.u_fifo.count); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (memory_write_request !== 1'b0 || memory_read_request !== 1'b0) begin errors++; $display("FAIL rstw_req_drop: got wr %0b rd %0b, required 0 0", memory_write_request, memory_read_request); end
        checks++; if (memory_addr !== 32'h0 || memory_write_data !== 32'h0) begin errors++; $display("FAIL rstw_mem_bus: got %h %h, required 0 0", memory_addr, memory_write_data); end
        checks++; if (cache_response !== 1'b0 || cache_read_data !== 32'h0) begin errors++; $display("FAIL rstw_cache_out: got %0b %h, required 0 0", cache_response, cache_read_data); end
        checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL rstw_count: got %0d, required 0", dut.u_fifo.count); end
        reset = 1'b0;
        exp_wr_q.delete();
        mem_seen_q.delete();
        wr_base   = wr_req_cycles;
        resp_base = resp_cnt;
        mem_stall = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (wr_req_cycles != wr_base) begin errors++; $display("FAIL rstw_no_requests: got %0d write cycles, required %0d", wr_req_cycles, wr_base); end
        checks++; if (resp_cnt != resp_base) begin errors++; $display("FAIL rstw_no_ack: got %0d acks, required %0d", resp_cnt, resp_base); end
    endtask

    task automatic test_idle_outputs();
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL idle_mem_bus_zero: got %0d nonzero idle cycles, required 0", idle_bad); end
    endtask

    initial begin
        reset               = 1'b1;
        cache_read_request  = 1'b0;
        cache_write_request = 1'b0;
        cache_addr          = '0;
        cache_write_data    = '0;
        mem_stall           = 1'b0;
        mem_lat             = 1;
        mem_rdata           = '0;
        test_reset();
        test_single_write();
        test_full_stall();
        test_fifo_order();
        test_read();
        test_forward();
        test_simultaneous();
        test_reset_during_write();
        test_idle_outputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of buffered write entries; it SHALL be a power of two and at least 2.
REQ-002 SHALL have port clk  input  1  as its single clock.
REQ-003 SHALL have port reset  input  1  as a synchronous, active-high reset.
REQ-004 SHALL have ports cache_read_request and cache_write_request  input  1  as level requests from the data cache.
REQ-005 SHALL have ports cache_addr and cache_write_data  input  32  as the upstream address and write word.
REQ-006 SHALL have port cache_response  output  1  as a one-cycle completion pulse to the cache.
REQ-007 SHALL have port cache_read_data  output  32  as the read word, valid while cache_response is high.
REQ-008 SHALL have ports memory_read_request and memory_write_request  output  1  as level requests to memory.
REQ-009 SHALL have ports memory_addr and memory_write_data  output  32  as the downstream address and write word.
REQ-010 SHALL have port memory_response  input  1  as the memory completion pulse.
REQ-011 SHALL have port memory_read_data  input  32  as the memory read word.

Function
REQ-012 SHALL accept a write at a rising edge where cache_write_request=1, count<DEPTH and cache_response=0; it SHALL push {cache_addr, cache_write_data}.
REQ-013 SHALL pulse cache_response for exactly one cycle, in the cycle after the write is accepted, independent of memory progress.
REQ-014 SHALL ignore requests while cache_response=1, so a single held request is never accepted twice.
REQ-015 SHALL stall a write while the buffer is full, even if a pop occurs at the same edge; the write is accepted at the next edge after space exists.
REQ-016 SHALL run a memory FSM with states IDLE, WRITE and READ.
REQ-017 IDLE transitions: an eligible read goes to READ; otherwise a non-empty buffer goes to WRITE; otherwise remain in IDLE. A read has priority over a drain.
REQ-018 In WRITE, SHALL drive memory_write_request=1 with memory_addr/memory_write_data from the oldest entry; on memory_response it SHALL pop that entry and return to IDLE.
REQ-019 In READ, SHALL drive memory_read_request=1 with memory_addr=cache_addr; on memory_response it SHALL register memory_read_data into cache_read_data, pulse cache_response next cycle, and return to IDLE.
REQ-020 SHALL register memory outputs; each request SHALL deassert in the cycle after memory_response is sampled, and the memory_* data outputs SHALL be 0 in IDLE.
REQ-021 SHALL complete writes to memory in strict FIFO order.
REQ-022 SHALL hold cache_read_data at its last value between responses.
REQ-023 SHALL accept simultaneous cache_read_request and cache_write_request as the write only.

Reset
REQ-024 On reset, SHALL force the FSM to IDLE, set count and both pointers to 0, discard pending entries, and drive every output to 0.
REQ-025 On reset during WRITE or READ, SHALL drop the memory request in the next cycle and issue no cache_response for the aborted operation.

Configuration
REQ-026 With macro WRITE_BUFFER_FORWARD_EN defined, a read whose addr[31:2] matches a buffered entry SHALL be answered from the youngest matching entry, with cache_response one cycle later and no memory access.
REQ-027 With WRITE_BUFFER_FORWARD_EN defined, a non-matching read SHALL be eligible immediately and may bypass pending writes.
REQ-028 Without WRITE_BUFFER_FORWARD_EN, a read SHALL be eligible only when count=0, so it waits for a full drain.

Structure
REQ-029 FSM state encoding and the DEPTH default SHALL live in the shared memory-subsystem package.
REQ-030 Entry storage and pointers SHALL be one sub-module, wb_fifo (push, pop, full, empty, count, head entry, entry array for the match logic).

Verification
REQ-031 Write 0x100<-0xDEADBEEF with memory idle: cache_response 1 cycle later, then memory_write_request with addr 0x100 and data 0xDEADBEEF; after memory_response, count=0.
REQ-032 5 writes, DEPTH=4, memory stalled: 4 responses; the 5th write is held until the first memory_response pop, then accepted.
REQ-033 Writes A=0x10 and B=0x20 pending, then memory releases: memory sees A then B, in order.
REQ-034 FORWARD_EN: write 0x40<-1 then 0x40<-2 pending, read 0x40: cache_read_data=2 next cycle with no memory_read_request. Without the macro: the read is issued only after both writes complete, and returns the memory value.
REQ-035 Read 0x80 with memory returning 0x12345678: cache_response with cache_read_data=0x12345678 one cycle after memory_response.
REQ-036 Reset asserted during WRITE with 3 entries: all outputs 0 next cycle, count=0, and no further memory requests.
